crossbar_8x8_read_data: RTL and testbench

Read-side crossbar between the 8 LSU read ports and the 8 bank groups (BG); the return-path counterpart of the write crossbar. Each cycle it arbitrates LSU read requests per BG, forwards the winning `{ren, addr}` to that BG and grants the winner. A per-BG owner-tag pipeline tracks each issued read, and the BG read data is routed back to the issuing LSU through a registered response stage.

---
 rtl/crossbar_8x8_read_data_if.sv | 24 ++
 rtl/crossbar_8x8_read_data.sv | 135 +++++++++++++
 tb/tb_crossbar_8x8_read_data.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_8x8_read_data_if.sv
// rtl/crossbar_8x8_read_data_if.sv - LSU read ports and bank-group links of the 8x8 read crossbar
interface crossbar_8x8_read_data_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [ADDR_W+3:0] LSU_R_req   [8];   // {sel[2:0], ren, addr}
   logic [7:0]        LSU_R_gnt;
   logic [7:0]        LSU_R_valid;
   logic [DATA_W-1:0] LSU_R_data  [8];
   logic [ADDR_W:0]   R_BG        [8];   // {ren, addr}
   logic [DATA_W-1:0] BG_rdata    [8];

   // LSU/BG side: drives requests and bank data, observes grants and responses
   modport master (
      output LSU_R_req, BG_rdata,
      input  LSU_R_gnt, LSU_R_valid, LSU_R_data, R_BG
   );

   // Crossbar side
   modport slave (
      input  LSU_R_req, BG_rdata,
      output LSU_R_gnt, LSU_R_valid, LSU_R_data, R_BG
   );
endinterface

// File: rtl/crossbar_8x8_read_data.sv
// rtl/crossbar_8x8_read_data.sv - 8x8 LSU/bank-group read crossbar with owner-tag return path
// Optional feature macro: CROSSBAR_RD_RR_ARB_EN (per-BG round-robin arbitration; default fixed priority).
module crossbar_8x8_read_data #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   crossbar_8x8_read_data_if.slave bus
);
   localparam int LAST = RD_LAT - 1;

   logic [7:0]        req_ren;
   logic [2:0]        req_sel   [8];
   logic [ADDR_W-1:0] req_addr  [8];
   logic [2:0]        prio_base [8];
   logic [7:0]        win_vld;
   logic [2:0]        win_idx   [8];

   logic [RD_LAT-1:0] tag_vld_q [8];
   logic [2:0]        tag_own_q [8][RD_LAT];
   logic [7:0]        valid_d;
   logic [7:0]        valid_q;
   logic [DATA_W-1:0] data_d    [8];
   logic [DATA_W-1:0] data_q    [8];

   // Split each LSU request into target BG, read enable and address
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         req_sel[k]  = bus.LSU_R_req[k][ADDR_W+3:ADDR_W+1];
         req_ren[k]  = bus.LSU_R_req[k][ADDR_W];
         req_addr[k] = bus.LSU_R_req[k][ADDR_W-1:0];
      end
   end

`ifdef CROSSBAR_RD_RR_ARB_EN
   logic [2:0] rr_ptr_q [8];

   // Move each BG's highest-priority slot just past the LSU it granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) rr_ptr_q[n] <= '0;
      end else begin
         for (int n = 0; n < 8; n++)
            if (win_vld[n]) rr_ptr_q[n] <= win_idx[n] + 3'd1;
      end
   end

   // Priority search starts at the round-robin pointer
   always_comb begin
      for (int n = 0; n < 8; n++) prio_base[n] = rr_ptr_q[n];
   end
`else
   // Fixed priority: search always starts at LSU0
   always_comb begin
      for (int n = 0; n < 8; n++) prio_base[n] = '0;
   end
`endif

   // Per-BG arbitration; scanning from lowest to highest priority lets the best candidate overwrite
   always_comb begin
      logic [2:0] cand;
      cand = '0;
      for (int n = 0; n < 8; n++) begin
         win_vld[n] = 1'b0;
         win_idx[n] = '0;
         for (int o = 7; o >= 0; o--) begin
            cand = prio_base[n] + 3'(o);
            if (req_ren[cand] && (req_sel[cand] == 3'(n))) begin
               win_vld[n] = 1'b1;
               win_idx[n] = cand;
            end
         end
      end
   end

   // Zero-latency grant to each winner and forwarding of its address to the BG
   always_comb begin
      for (int k = 0; k < 8; k++)
         bus.LSU_R_gnt[k] = req_ren[k] && win_vld[req_sel[k]] && (win_idx[req_sel[k]] == 3'(k));
      for (int n = 0; n < 8; n++)
         bus.R_BG[n] = win_vld[n] ? {1'b1, req_addr[win_idx[n]]} : '0;
   end

   // Owner-tag shift register per BG, aligned with the BG read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 8; n++) begin
            tag_vld_q[n] <= '0;
            for (int s = 0; s < RD_LAT; s++) tag_own_q[n][s] <= '0;
         end
      end else begin
         for (int n = 0; n < 8; n++) begin
            tag_vld_q[n][0] <= win_vld[n];
            tag_own_q[n][0] <= win_idx[n];
            for (int s = 1; s < RD_LAT; s++) begin
               tag_vld_q[n][s] <= tag_vld_q[n][s-1];
               tag_own_q[n][s] <= tag_own_q[n][s-1];
            end
         end
      end
   end

   // Route each returning BG word to the LSU named by its final-stage tag
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         valid_d[k] = 1'b0;
         data_d[k]  = data_q[k];
      end
      for (int n = 0; n < 8; n++) begin
         if (tag_vld_q[n][LAST]) begin
            valid_d[tag_own_q[n][LAST]] = 1'b1;
            data_d[tag_own_q[n][LAST]]  = bus.BG_rdata[n];
         end
      end
   end

   // Registered response stage; data holds between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < 8; k++) data_q[k] <= '0;
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 8; k++) data_q[k] <= data_d[k];
      end
   end

   // Drive response outputs from the registers
   always_comb begin
      bus.LSU_R_valid = valid_q;
      for (int k = 0; k < 8; k++) bus.LSU_R_data[k] = data_q[k];
   end
endmodule

// File: tb/tb_crossbar_8x8_read_data.sv
// tb/tb_crossbar_8x8_read_data.sv - directed self-checking bench for crossbar_8x8_read_data
module tb_crossbar_8x8_read_data;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   crossbar_8x8_read_data_if #(.ADDR_W(10), .DATA_W(32)) if1 ();
   crossbar_8x8_read_data_if #(.ADDR_W(10), .DATA_W(32)) if3 ();

   crossbar_8x8_read_data #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_lat1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   crossbar_8x8_read_data #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) u_lat3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] mkreq(input logic [2:0] sel, input logic ren, input logic [9:0] addr);
      return {sel, ren, addr};
   endfunction

   // Advance to 1 time unit after the next rising edge (input drive point)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sampling point, well away from both clock edges
   task automatic settle();
      #3;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 8; i++) begin
         if1.LSU_R_req[i] = '0;
         if1.BG_rdata[i]  = '0;
         if3.LSU_R_req[i] = '0;
         if3.BG_rdata[i]  = '0;
      end
   endtask

   initial begin
      logic [7:0] rr_exp [4];
      n_checks = 0;
      n_fails  = 0;
      idle_all();

      // Reset state
      rst_n = 1'b0;
      #2;
      check("rst_valid_lat1", if1.LSU_R_valid, 8'h00);
      check("rst_valid_lat3", if3.LSU_R_valid, 8'h00);
      check("rst_data2_lat1", if1.LSU_R_data[2], 32'h0);
      check("rst_rbg0_idle", if1.R_BG[0], 11'h000);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single read, RD_LAT=1: LSU2 -> BG5
      if1.LSU_R_req[2] = mkreq(3'd5, 1'b1, 10'h01A);
      settle();
      check("single_gnt", if1.LSU_R_gnt, 8'h04);
      check("single_rbg5", if1.R_BG[5], 11'h41A);
      check("single_rbg0", if1.R_BG[0], 11'h000);
      step();
      if1.LSU_R_req[2] = '0;
      if1.BG_rdata[5]  = 32'hDEADBEEF;
      settle();
      check("single_valid_t1", if1.LSU_R_valid, 8'h00);
      step();
      if1.BG_rdata[5] = '0;
      settle();
      check("single_valid_t2", if1.LSU_R_valid, 8'h04);
      check("single_data_t2", if1.LSU_R_data[2], 32'hDEADBEEF);
      step();
      settle();
      check("single_valid_t3", if1.LSU_R_valid, 8'h00);

      // ren=0 request is ignored
      step();
      if1.LSU_R_req[0] = mkreq(3'd1, 1'b0, 10'h3FF);
      settle();
      check("ren0_gnt", if1.LSU_R_gnt, 8'h00);
      check("ren0_rbg1", if1.R_BG[1], 11'h000);
      step();
      if1.LSU_R_req[0] = '0;

      // Conflict on BG3 between LSU1 and LSU6
      if1.LSU_R_req[1] = mkreq(3'd3, 1'b1, 10'h011);
      if1.LSU_R_req[6] = mkreq(3'd3, 1'b1, 10'h066);
      settle();
      check("conf_gnt_t0", if1.LSU_R_gnt, 8'h02);
      check("conf_rbg3_t0", if1.R_BG[3], 11'h411);
      step();
      if1.LSU_R_req[1] = '0;
      if1.BG_rdata[3]  = 32'hAAAA0001;
      settle();
      check("conf_gnt_t1", if1.LSU_R_gnt, 8'h40);
      check("conf_rbg3_t1", if1.R_BG[3], 11'h466);
      step();
      if1.LSU_R_req[6] = '0;
      if1.BG_rdata[3]  = 32'hBBBB0006;
      settle();
      check("conf_valid_t2", if1.LSU_R_valid, 8'h02);
      check("conf_data1_t2", if1.LSU_R_data[1], 32'hAAAA0001);
      step();
      if1.BG_rdata[3] = '0;
      settle();
      check("conf_valid_t3", if1.LSU_R_valid, 8'h40);
      check("conf_data6_t3", if1.LSU_R_data[6], 32'hBBBB0006);
      step();
      settle();
      check("conf_valid_t4", if1.LSU_R_valid, 8'h00);
      check("conf_data1_hold", if1.LSU_R_data[1], 32'hAAAA0001);

      // LSU0 and LSU4 contend for BG0 for four cycles
`ifdef CROSSBAR_RD_RR_ARB_EN
      rr_exp[0] = 8'h01; rr_exp[1] = 8'h10; rr_exp[2] = 8'h01; rr_exp[3] = 8'h10;
`else
      rr_exp[0] = 8'h01; rr_exp[1] = 8'h01; rr_exp[2] = 8'h01; rr_exp[3] = 8'h01;
`endif
      step();
      if1.LSU_R_req[0] = mkreq(3'd0, 1'b1, 10'h000);
      if1.LSU_R_req[4] = mkreq(3'd0, 1'b1, 10'h004);
      for (int c = 0; c < 4; c++) begin
         settle();
         check($sformatf("arb_gnt_c%0d", c), if1.LSU_R_gnt, rr_exp[c]);
         step();
      end
      if1.LSU_R_req[0] = '0;
      if1.LSU_R_req[4] = '0;
      step();
      step();
      step();

      // Full permutation: LSU i -> BG 7-i, every cycle for 10 cycles
      for (int i = 0; i < 8; i++) begin
         if1.LSU_R_req[i] = mkreq(3'(7 - i), 1'b1, 10'(i));
         if1.BG_rdata[i]  = 32'h100 + 32'(i);
      end
      for (int c = 0; c < 10; c++) begin
         settle();
         check($sformatf("perm_gnt_c%0d", c), if1.LSU_R_gnt, 8'hFF);
         if (c >= 2) begin
            check($sformatf("perm_valid_c%0d", c), if1.LSU_R_valid, 8'hFF);
            for (int i = 0; i < 8; i++)
               check($sformatf("perm_data%0d_c%0d", i, c), if1.LSU_R_data[i], 32'h100 + 32'(7 - i));
         end
         step();
      end
      idle_all();

      // Reset mid-flight, RD_LAT=3: grant in T, reset pulsed during T+1
      if3.LSU_R_req[2] = mkreq(3'd5, 1'b1, 10'h01A);
      settle();
      check("mid_gnt", if3.LSU_R_gnt, 8'h04);
      step();
      if3.LSU_R_req[2] = '0;
      rst_n = 1'b0;
      settle();
      check("mid_rst_valid_lat3", if3.LSU_R_valid, 8'h00);
      check("mid_rst_valid_lat1", if1.LSU_R_valid, 8'h00);
      check("mid_rst_data0_lat1", if1.LSU_R_data[0], 32'h0);
      check("mid_rst_data7_lat1", if1.LSU_R_data[7], 32'h0);
      rst_n = 1'b1;
      for (int c = 2; c < 7; c++) begin
         step();
         if (c == 3) if3.BG_rdata[5] = 32'hCAFEF00D;
         else        if3.BG_rdata[5] = '0;
         settle();
         check($sformatf("mid_no_valid_t%0d", c), if3.LSU_R_valid, 8'h00);
      end

      // Single read with RD_LAT=3: data presented in T+3, response in T+4
      step();
      if3.LSU_R_req[2] = mkreq(3'd5, 1'b1, 10'h01A);
      settle();
      check("lat3_gnt", if3.LSU_R_gnt, 8'h04);
      check("lat3_rbg5", if3.R_BG[5], 11'h41A);
      step();
      if3.LSU_R_req[2] = '0;
      for (int c = 1; c < 4; c++) begin
         if (c == 3) if3.BG_rdata[5] = 32'h12345678;
         settle();
         check($sformatf("lat3_valid_t%0d", c), if3.LSU_R_valid, 8'h00);
         step();
      end
      if3.BG_rdata[5] = '0;
      settle();
      check("lat3_valid_t4", if3.LSU_R_valid, 8'h04);
      check("lat3_data_t4", if3.LSU_R_data[2], 32'h12345678);
      step();
      settle();
      check("lat3_valid_t5", if3.LSU_R_valid, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
